// File: rtl/register_file.sv
// 32-entry general-purpose register file: two combinational read ports with
// write-through bypass, one writeback port and a dedicated link-write port.

module register_file_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end
endmodule

module register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data
);
  localparam int                NUM_REGS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t wb_req, lk_req;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [1:0][ADDR_W-1:0]          rd_addr;
  logic [1:0][DATA_W-1:0]          rd_data;

  // Writes to $0 are dropped at the request, so neither storage nor bypass sees them.
  assign wb_req = '{en: wr_en && (wr_addr != '0), addr: wr_addr, data: wr_data};
  assign lk_req = '{en: link_en && (LINK_ADDR != '0), addr: LINK_ADDR, data: link_data};

  assign regs[0] = '0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    logic              lk_hit, wb_hit;
    logic [DATA_W-1:0] d;
    assign lk_hit = lk_req.en && (lk_req.addr == ADDR_W'(gi));
    assign wb_hit = wb_req.en && (wb_req.addr == ADDR_W'(gi));
    // Link wins a collision on the same register.
    assign d      = lk_hit ? lk_req.data : wb_req.data;

    register_file_cell #(.DATA_W(DATA_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (lk_hit | wb_hit),
      .d     (d),
      .q     (regs[gi])
    );
  end

  assign rd_addr[0] = rs_addr;
  assign rd_addr[1] = rt_addr;
  assign rs_data    = rd_data[0];
  assign rt_data    = rd_data[1];

  for (genvar gp = 0; gp < 2; gp++) begin : g_rd
    always_comb begin
      rd_data[gp] = regs[rd_addr[gp]];
      if (wb_req.en && (rd_addr[gp] == wb_req.addr)) rd_data[gp] = wb_req.data;
      if (lk_req.en && (rd_addr[gp] == lk_req.addr)) rd_data[gp] = lk_req.data;
      if (!rst_n || (rd_addr[gp] == '0))             rd_data[gp] = '0;
    end
  end
endmodule
